// File: rtl/unary_matmul_engine.sv
// Signed DIM x DIM matrix multiplier built on temporal-unary pulse counting, with a start/busy/done handshake.
// Define UNARY_EARLY_TERM_EN to shorten the run to the largest latched operand magnitudes.
module unary_matmul_engine #(
  parameter int DIM   = 16,
  parameter int WIDTH = 4,
  parameter int OUT_W = 2*WIDTH + $clog2(DIM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     accumulate,
  input  logic [DIM*DIM*WIDTH-1:0] in_a,
  input  logic [DIM*DIM*WIDTH-1:0] in_b,
  output logic [DIM*DIM*OUT_W-1:0] out,
  output logic                     busy,
  output logic                     done
);

  localparam int DW = $clog2(DIM+1) + 1;
  localparam logic [WIDTH-1:0] M_LIM = WIDTH'(1) << (WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] p_reg, t_reg;
  logic [WIDTH-1:0] pl, tl;
  logic [WIDTH-1:0] mag_a_reg [DIM][DIM];
  logic [WIDTH-1:0] mag_b_reg [DIM][DIM];
  logic             sgn_a_reg [DIM][DIM];
  logic             sgn_b_reg [DIM][DIM];
  logic             abit      [DIM][DIM];
  logic             bbit      [DIM][DIM];
  logic             accept;
  logic             last_cycle;

  // Magnitude of a two's complement value; -M maps to M, which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign accept     = (state_reg == IDLE) && start;
  assign last_cycle = (state_reg == RUN) && (p_reg == pl - 1'b1) && (t_reg == tl - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          mag_a_reg[i][k] <= '0;
          mag_b_reg[i][k] <= '0;
          sgn_a_reg[i][k] <= 1'b0;
          sgn_b_reg[i][k] <= 1'b0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          mag_a_reg[i][k] <= mag_of(in_a[(i*DIM+k)*WIDTH +: WIDTH]);
          mag_b_reg[i][k] <= mag_of(in_b[(i*DIM+k)*WIDTH +: WIDTH]);
          sgn_a_reg[i][k] <= in_a[(i*DIM+k)*WIDTH + WIDTH-1];
          sgn_b_reg[i][k] <= in_b[(i*DIM+k)*WIDTH + WIDTH-1];
        end
      end
    end
  end

`ifdef UNARY_EARLY_TERM_EN
  logic [WIDTH-1:0] max_a, max_b;

  // Limits follow the latched operands, floored at 1 so an all-zero run still lasts one cycle.
  always_comb begin
    max_a = '0;
    max_b = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (mag_a_reg[i][k] > max_a) max_a = mag_a_reg[i][k];
        if (mag_b_reg[i][k] > max_b) max_b = mag_b_reg[i][k];
      end
    end
    pl = (max_a == '0) ? WIDTH'(1) : max_a;
    tl = (max_b == '0) ? WIDTH'(1) : max_b;
  end
`else
  assign pl = M_LIM;
  assign tl = M_LIM;
`endif

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        abit[i][k] = (p_reg < mag_a_reg[i][k]);
        bbit[i][k] = (t_reg < mag_b_reg[i][k]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      t_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= RUN;
            busy      <= 1'b1;
            p_reg     <= '0;
            t_reg     <= '0;
          end
        end
        RUN: begin
          if (last_cycle) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            p_reg     <= '0;
            t_reg     <= '0;
          end else if (t_reg == tl - 1'b1) begin
            t_reg <= '0;
            p_reg <= p_reg + 1'b1;
          end else begin
            t_reg <= t_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_row
      for (gj = 0; gj < DIM; gj++) begin : g_col
        logic signed [DW-1:0] delta;
        logic [OUT_W-1:0]     out_reg;

        always_comb begin
          delta = '0;
          for (int k = 0; k < DIM; k++) begin
            if (abit[gi][k] && bbit[k][gj]) begin
              if (sgn_a_reg[gi][k] ^ sgn_b_reg[k][gj]) delta = delta - DW'(1);
              else                                     delta = delta + DW'(1);
            end
          end
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            out_reg <= '0;
          end else if (accept && !accumulate) begin
            out_reg <= '0;
          end else if (state_reg == RUN) begin
            out_reg <= out_reg + {{(OUT_W-DW){delta[DW-1]}}, delta};
          end
        end

        assign out[(gi*DIM+gj)*OUT_W +: OUT_W] = out_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_unary_matmul_engine.sv
// Scoreboard bench for unary_matmul_engine: directed operand sets, expected results queued at issue time.
module tb_unary_matmul_engine;

  localparam int DIM   = 16;
  localparam int WIDTH = 4;
  localparam int OUT_W = 2*WIDTH + $clog2(DIM);
  localparam int AV    = DIM*DIM*WIDTH;
  localparam int OV    = DIM*DIM*OUT_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          accumulate;
  logic [AV-1:0] in_a;
  logic [AV-1:0] in_b;
  logic [OV-1:0] out;
  logic          busy;
  logic          done;

  typedef struct {
    string         name;
    logic [OV-1:0] out;
    int            cyc;
    int            lat;
  } exp_t;

  exp_t          q[$];
  logic [OV-1:0] exp_vec;
  int            cyc      = 0;
  int            busy_cnt = 0;
  int            errors   = 0;
  int            checks   = 0;

  unary_matmul_engine #(.DIM(DIM), .WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumulate (accumulate),
    .in_a       (in_a),
    .in_b       (in_b),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic set_a(input int i, input int k, input int v);
    in_a[(i*DIM+k)*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic set_b(input int k, input int j, input int v);
    in_b[(k*DIM+j)*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic set_e(input int i, input int j, input int v);
    exp_vec[(i*DIM+j)*OUT_W +: OUT_W] = OUT_W'(v);
  endtask

  task automatic fill_all(input int va, input int vb, input int ve);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        set_a(i, j, va);
        set_b(i, j, vb);
        set_e(i, j, ve);
      end
  endtask

  // Issue one request; lat_def / lat_et are the hand-derived run lengths without / with early termination.
  task automatic issue(input string name, input logic acc, input int lat_def, input int lat_et,
                       input logic push);
    exp_t e;
    int   lat;
`ifdef UNARY_EARLY_TERM_EN
    lat = lat_et;
`else
    lat = lat_def;
`endif
    @(negedge clk);
    accumulate = acc;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name = name;
      e.out  = exp_vec;
      e.cyc  = cyc + lat;
      e.lat  = lat;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 200 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen within 200 cycles, %0d results pending", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   first;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done at cycle %0d: got done=1 required no pulse", cyc);
        end else begin
          e = q.pop_front();
          checks++;
          if (out !== e.out) begin
            errors++;
            first = 0;
            for (int n = DIM*DIM-1; n >= 0; n--)
              if (out[n*OUT_W +: OUT_W] !== e.out[n*OUT_W +: OUT_W]) first = n;
            $display("FAIL %s_out [%0d][%0d]: got %0d required %0d", e.name, first / DIM, first % DIM,
                     $signed(out[first*OUT_W +: OUT_W]), $signed(e.out[first*OUT_W +: OUT_W]));
          end else begin
            $display("%s: out ok at cycle %0d", e.name, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d required %0d", e.name, cyc, e.cyc);
          end
          checks++;
          if (busy_cnt != e.lat) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", e.name, busy_cnt, e.lat);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [AV-1:0] save_a;
    reset      = 1'b1;
    start      = 1'b0;
    accumulate = 1'b0;
    in_a       = '0;
    in_b       = '0;
    exp_vec    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got nonzero required 0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end

    // Identity 4x4 corner times b[k][j] = k-j gives out[i][j] = i-j in the corner
    fill_all(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_a(i, i, 1);
      for (int j = 0; j < 4; j++) begin
        set_b(i, j, i - j);
        set_e(i, j, i - j);
      end
    end
    issue("identity", 1'b0, 64, 3, 1'b1);
    wait_idle("identity");

    fill_all(-8, 7, -896);
    issue("neg8x7", 1'b0, 64, 56, 1'b1);
    wait_idle("neg8x7");

    fill_all(-8, 7, -1792);
    issue("accum", 1'b1, 64, 56, 1'b1);
    wait_idle("accum");

    fill_all(-8, 7, -896);
    issue("clear", 1'b0, 64, 56, 1'b1);
    wait_idle("clear");

    // A start pulse mid-run with different operands must be ignored
    issue("restart_ignored", 1'b0, 64, 56, 1'b1);
    repeat (9) @(negedge clk);
    save_a     = in_a;
    fill_all(1, 7, -896);
    accumulate = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_a  = save_a;
    wait_idle("restart_ignored");

    // Reset mid-run: nothing queued, so any done pulse is flagged by the monitor
    fill_all(-8, 7, -896);
    issue("abort", 1'b0, 64, 56, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out !== '0) begin errors++; $display("FAIL abort_out: got nonzero required 0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    reset = 1'b0;
    repeat (80) @(negedge clk);
    checks++; if (out !== '0) begin errors++; $display("FAIL abort_hold_out: got nonzero required 0"); end
    $display("abort: no done observed after mid-run reset");
    issue("after_abort", 1'b1, 64, 56, 1'b1);
    wait_idle("after_abort");

    // Small operands: max|a| = 1, max|b| = 2
    fill_all(0, 0, 0);
    set_a(0, 0, 1);
    set_a(1, 0, -1);
    set_b(0, 0, 2);
    set_b(0, 1, -1);
    set_e(0, 0, 2);
    set_e(0, 1, -1);
    set_e(1, 0, -2);
    set_e(1, 1, 1);
    issue("small", 1'b0, 64, 2, 1'b1);
    wait_idle("small");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
